// File: rtl/systolic_scheduler.sv
// Control sequencer for one pass through the PE grid: weight load,
// weight switch, skewed input streaming and pipeline drain.
module systolic_scheduler #(
   parameter int ROWS   = 2,
   parameter int COLS   = 2,
   parameter int DATA_W = 16,
   parameter int NV_W   = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [NV_W-1:0]        num_vecs,
   output logic                   busy,
   output logic                   done,
   input  logic                   w_valid,
   output logic                   w_ready,
   input  logic [COLS*DATA_W-1:0] w_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [ROWS*DATA_W-1:0] in_data,
   output logic                   sys_enable,
   output logic                   sys_accept_w,
   output logic [COLS*DATA_W-1:0] sys_weight,
   output logic                   sys_switch,
   output logic [ROWS-1:0]        sys_valid,
   output logic [ROWS*DATA_W-1:0] sys_input
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD_W = 3'd1;
   localparam logic [2:0] S_SWITCH = 3'd2;
   localparam logic [2:0] S_STREAM = 3'd3;
   localparam logic [2:0] S_DRAIN  = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   localparam int WC_W = $clog2(ROWS + 1);
   localparam int DC_W = $clog2(ROWS + COLS + 1);
   localparam logic [WC_W-1:0] WC_LAST = WC_W'(ROWS - 1);
   localparam logic [DC_W-1:0] DC_LAST = DC_W'(ROWS + COLS - 1);

   logic [2:0]      state_q, state_d;
   logic [WC_W-1:0] wcnt_q, wcnt_d;
   logic [DC_W-1:0] dcnt_q, dcnt_d;
   logic [NV_W-1:0] vcnt_q, vcnt_d;
   logic [NV_W-1:0] nv_q, nv_d;
   logic            w_acc, in_acc;

   assign w_acc  = (state_q == S_LOAD_W) & w_valid;
   assign in_acc = (state_q == S_STREAM) & in_valid;

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      dcnt_d  = dcnt_q;
      vcnt_d  = vcnt_q;
      nv_d    = nv_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               nv_d    = num_vecs;
               wcnt_d  = '0;
               vcnt_d  = '0;
               dcnt_d  = '0;
               state_d = S_LOAD_W;
            end
         end
         S_LOAD_W: begin
            if (w_acc) begin
               wcnt_d = wcnt_q + WC_W'(1);
               if (wcnt_q == WC_LAST) state_d = S_SWITCH;
            end
         end
         S_SWITCH: begin
            state_d = (nv_q == '0) ? S_DONE : S_STREAM;
         end
         S_STREAM: begin
            // compare against nv-1 so nv = 2^NV_W-1 never wraps vcnt
            if (in_acc) begin
               vcnt_d = vcnt_q + NV_W'(1);
               if (vcnt_q == nv_q - NV_W'(1)) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            dcnt_d = dcnt_q + DC_W'(1);
            if (dcnt_q == DC_LAST) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         wcnt_q  <= '0;
         dcnt_q  <= '0;
         vcnt_q  <= '0;
         nv_q    <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         dcnt_q  <= dcnt_d;
         vcnt_q  <= vcnt_d;
         nv_q    <= nv_d;
      end
   end

   assign busy         = (state_q != S_IDLE);
   assign done         = (state_q == S_DONE);
   assign w_ready      = (state_q == S_LOAD_W);
   assign in_ready     = (state_q == S_STREAM);
   assign sys_enable   = busy;
   assign sys_accept_w = w_acc;
   assign sys_weight   = w_acc ? w_data : '0;
   assign sys_switch   = (state_q == S_SWITCH);

   // lane r sees r+1 register stages; bubbles travel as valid=0, data=0
   for (genvar gr = 0; gr < ROWS; gr++) begin : g_lane
      logic [gr:0]       v_q;
      logic [DATA_W-1:0] d_q [gr+1];

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            v_q <= '0;
            for (int k = 0; k <= gr; k++) d_q[k] <= '0;
         end else begin
            v_q[0] <= in_acc;
            d_q[0] <= in_acc ? in_data[gr*DATA_W +: DATA_W] : '0;
            for (int k = 1; k <= gr; k++) begin
               v_q[k] <= v_q[k-1];
               d_q[k] <= d_q[k-1];
            end
         end
      end

      assign sys_valid[gr]                  = v_q[gr];
      assign sys_input[gr*DATA_W +: DATA_W] = d_q[gr];
   end

endmodule
